mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit with its sequencing controller for the 5-stage MIPS pipeline. Sits beside the E-stage ALU and owns the HI/LO registers. Runs the multi-cycle latency model: MULT/MULTU take MULT_CYCLES, DIV/DIVU take DIV_CYCLES. Raises a stall request to the hazard unit while an MD-class instruction in E must wait for the unit.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  E-stage issue strobe for the op on md_op; sampled on the rising edge
md_op  in  3  operation code; encodings in mdu_pkg
rs_val  in  32  operand A (forwarded rs)
rt_val  in  32  operand B (forwarded rt)
md_use_e  in  1  E-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo)
busy  out  1  unit computing
stall_req  out  1  stall F/D and bubble E
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset: async. busy=0, hi=0, lo=0, state=IDLE, counter=0, operand/result latches=0. stall_req=0 while reset is high.
- md_op values: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NOP.
- States: IDLE, BUSY.
- IDLE + start + mult/div op:
  - Latch the 64-bit result from md_arith.
  - counter <= MULT_CYCLES or DIV_CYCLES.
  - -> BUSY.
- BUSY: counter decrements each edge. When counter==1 at the edge: hi/lo <= latched result, busy<=0, -> IDLE.
- Latency: start sampled at edge T. busy=1 during cycles T+1..T+N. New hi/lo are visible from T+N (same edge that drops busy).
- IDLE + start + MTHI/MTLO: hi or lo <= rs_val at that edge. No busy. The other register is unchanged.
- start while BUSY: must not occur, because stall_req blocks it. The bench asserts this. RTL ignores it and leaves the counter and latches untouched.
- stall_req = md_use_e & (busy | start_is_muldiv). This is combinational, so the cycle after issue also stalls a following mfhi. The issuing mult/div itself sees start high but has already advanced, so the hazard unit masks the self-stall by qualifying with the D-stage instruction. This signal is documented for it.
- Arithmetic:
  - MULT: signed 32x32->64.
  - MULTU: unsigned 32x32->64.
  - hi = upper 32 bits, lo = lower 32 bits.
  - DIV: signed. lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero: runs the full DIV_CYCLES with busy; hi/lo left unchanged.
- DIV 0x80000000 / -1: lo = 0x80000000, hi = 0 (wrap, no trap).
- Reset mid-operation: aborts immediately. hi/lo = 0, busy = 0, and the pending result is discarded.
- MTHI/MTLO during BUSY: must not occur (stalled).
- mfhi/mflo read hi/lo directly; the E-stage mux sits outside this block.

Decomposition:
- mdu_pkg:
  - md_op encodings: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default cycle constants.
- Sub-module md_arith: purely combinational 64-bit result for the four mult/div ops, including divide-by-zero and overflow handling. Also outputs a div_zero flag.
- mdu_ctrl contains the FSM, counter, latches, and the HI/LO registers.

Test Plan:
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. Register values unchanged while busy.
- DIVU rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rt=0 after MTHI 0x1234 / MTLO 0x5678 -> 10 busy cycles, then hi=0x1234, lo=0x5678 unchanged. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MULTU then mfhi issued next (md_use_e=1) -> stall_req=1 for the start cycle plus all 5 busy cycles, 0 afterwards. The mfhi reads the new hi=0xFFFFFFFE for 0xFFFFFFFF*0xFFFFFFFF.
- Reset asserted asynchronously in the 3rd busy cycle of DIV -> busy, hi, lo drop to 0 without a clock edge. After release, the unit is IDLE and accepts a new MULT.
- MTLO 0xDEADBEEF while idle -> lo updates at that edge, busy stays 0, stall_req=0 with md_use_e=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic is_muldiv(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage issue / hazard / HI-LO bundle between the pipeline and the MDU.
interface mdu_ctrl_if;
    import mdu_pkg::*;

    logic              start;
    md_op_e            md_op;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic              md_use_e;
    logic              busy;
    logic              stall_req;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    modport master (
        output start, md_op, rs_val, rt_val, md_use_e,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, md_use_e,
        output busy, stall_req, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
module md_arith
    import mdu_pkg::*;
(
    input  md_op_e            i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_result,
    output logic              o_div_zero
);

    logic signed [2*XLEN-1:0] w_sa;
    logic signed [2*XLEN-1:0] w_sb;
    logic signed [2*XLEN-1:0] w_sprod;
    logic        [2*XLEN-1:0] w_uprod;
    logic                     w_signed;
    logic                     w_a_neg;
    logic                     w_b_neg;
    logic        [XLEN-1:0]   w_dvd;
    logic        [XLEN-1:0]   w_dvs;
    logic        [XLEN-1:0]   w_dvs_safe;
    logic        [XLEN-1:0]   w_q_u;
    logic        [XLEN-1:0]   w_r_u;
    logic        [XLEN-1:0]   w_q;
    logic        [XLEN-1:0]   w_r;

    assign w_sa    = {{XLEN{i_a[XLEN-1]}}, i_a};
    assign w_sb    = {{XLEN{i_b[XLEN-1]}}, i_b};
    assign w_sprod = w_sa * w_sb;
    assign w_uprod = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign w_signed   = (i_op == MD_DIV);
    assign w_a_neg    = w_signed & i_a[XLEN-1];
    assign w_b_neg    = w_signed & i_b[XLEN-1];
    assign w_dvd      = w_a_neg ? (~i_a + XLEN'(1)) : i_a;
    assign w_dvs      = w_b_neg ? (~i_b + XLEN'(1)) : i_b;
    assign w_dvs_safe = (w_dvs == '0) ? XLEN'(1) : w_dvs;
    assign w_q_u      = w_dvd / w_dvs_safe;
    assign w_r_u      = w_dvd % w_dvs_safe;
    assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_q_u + XLEN'(1)) : w_q_u;
    assign w_r        = w_a_neg ? (~w_r_u + XLEN'(1)) : w_r_u;

    assign o_div_zero = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == '0);

    always_comb begin
        o_result = '0;
        case (i_op)
            MD_MULT:          o_result = w_sprod;
            MD_MULTU:         o_result = w_uprod;
            MD_DIV, MD_DIVU:  o_result = {w_r, w_q};
            default:          o_result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU sequencer: owns HI/LO, models mult/div latency, raises stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
)(
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    mdu_state_e           r_state;
    mdu_state_e           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [2*XLEN-1:0]    r_res;
    logic [2*XLEN-1:0]    w_res_nxt;
    logic                 r_div_zero;
    logic                 w_div_zero_nxt;
    logic [XLEN-1:0]      r_hi;
    logic [XLEN-1:0]      w_hi_nxt;
    logic [XLEN-1:0]      r_lo;
    logic [XLEN-1:0]      w_lo_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;

    logic [2*XLEN-1:0]    w_arith_res;
    logic                 w_arith_dz;
    logic                 w_start_md;

    md_arith u_arith (
        .i_op       (bus.md_op),
        .i_a        (bus.rs_val),
        .i_b        (bus.rt_val),
        .o_result   (w_arith_res),
        .o_div_zero (w_arith_dz)
    );

    assign w_start_md    = bus.start & is_muldiv(bus.md_op);
    // Combinational so a dependent MD op right behind the issuing one is held in E.
    assign bus.stall_req = ~reset & bus.md_use_e & (r_busy | w_start_md);
    assign bus.busy      = r_busy;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_res      <= '0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_res      <= w_res_nxt;
            r_div_zero <= w_div_zero_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_res_nxt      = r_res;
        w_div_zero_nxt = r_div_zero;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_busy_nxt     = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_start_md) begin
                    w_res_nxt      = w_arith_res;
                    w_div_zero_nxt = w_arith_dz;
                    w_cnt_nxt      = is_mult(bus.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_BUSY;
                end else if (bus.start && (bus.md_op == MD_MTHI)) begin
                    w_hi_nxt = bus.rs_val;
                end else if (bus.start && (bus.md_op == MD_MTLO)) begin
                    w_lo_nxt = bus.rs_val;
                end
            end
            S_BUSY: begin
                // Issue strobes here are ignored; the hazard unit keeps them out.
                if (r_cnt == CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                    if (!r_div_zero) begin
                        w_hi_nxt = r_res[2*XLEN-1:XLEN];
                        w_lo_nxt = r_res[XLEN-1:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed table, hand sequences, random vs model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk;
    logic reset;

    mdu_ctrl_if u_if ();

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_e;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one op, straight from the ISA definition.
    task automatic model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l);
        int          sa;
        int          sb;
        longint      la;
        longint      lb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] up;
        sa = a; sb = b; la = sa; lb = sb;
        case (op)
            MD_MULT:  begin p = la * lb; h = p[63:32]; l = p[31:0]; end
            MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
            MD_DIV:   if (b != 0) begin q = la / lb; r = la % lb; l = q[31:0]; h = r[31:0]; end
            MD_DIVU:  if (b != 0) begin l = a / b; h = a % b; end
            MD_MTHI:  h = a;
            MD_MTLO:  l = a;
            default:  ;
        endcase
    endtask

    // Issue one op, then check stall/busy/HI/LO every cycle until it retires.
    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_e, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string tag);
        int unsigned n;
        logic        md;
        md = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        n  = ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_N : DIV_N;
        @(negedge clk);
        u_if.start = 1'b1; u_if.md_op = op; u_if.rs_val = a; u_if.rt_val = b; u_if.md_use_e = use_e;
        #1 check({tag, "_stall_issue"}, 32'(u_if.stall_req), 32'(use_e & md));
        @(negedge clk);
        u_if.start = 1'b0; u_if.md_op = MD_NOP;
        if (md) begin
            for (int i = 0; i < int'(n); i++) begin
                #1;
                check({tag, "_busy"},  32'(u_if.busy), 32'd1);
                check({tag, "_stall"}, 32'(u_if.stall_req), 32'(use_e));
                check({tag, "_hi_hold"}, u_if.hi, m_hi);
                check({tag, "_lo_hold"}, u_if.lo, m_lo);
                @(negedge clk);
            end
        end
        #1;
        check({tag, "_busy_done"},  32'(u_if.busy), 32'd0);
        check({tag, "_stall_done"}, 32'(u_if.stall_req), 32'd0);
        check({tag, "_hi"}, u_if.hi, exp_hi);
        check({tag, "_lo"}, u_if.lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
        u_if.md_use_e = 1'b0;
    endtask

    // The hazard unit must never let an issue reach a busy unit.
    always @(posedge clk) begin
        if (!reset && u_if.busy && u_if.start) begin
            n_errors++;
            $display("FAIL start_while_busy: start=1 busy=1 at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ue;
        logic [31:0] h;
        logic [31:0] l;

        n_checks = 0;
        n_errors = 0;
        m_hi = '0;
        m_lo = '0;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{MD_DIVU,  32'd100,      32'd7,        1'b0, 32'd2,        32'd14};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MD_MTHI,  32'h00001234, 32'd0,        1'b0, 32'h00001234, 32'hFFFFFFFD};
        vecs[4] = '{MD_MTLO,  32'h00005678, 32'd0,        1'b0, 32'h00001234, 32'h00005678};
        vecs[5] = '{MD_DIV,   32'd99,       32'd0,        1'b0, 32'h00001234, 32'h00005678};
        vecs[6] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
        vecs[7] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
        vecs[8] = '{MD_MTLO,  32'hDEADBEEF, 32'd0,        1'b1, 32'hFFFFFFFE, 32'hDEADBEEF};

        // Reset held with a live mult issue and md_use_e: everything quiet.
        reset = 1'b1;
        u_if.start = 1'b1; u_if.md_op = MD_MULT; u_if.md_use_e = 1'b1;
        u_if.rs_val = 32'h12345678; u_if.rt_val = 32'h9;
        #12;
        check("rst_busy",  32'(u_if.busy), 32'd0);
        check("rst_stall", 32'(u_if.stall_req), 32'd0);
        check("rst_hi",    u_if.hi, 32'd0);
        check("rst_lo",    u_if.lo, 32'd0);
        u_if.start = 1'b0; u_if.md_op = MD_NOP; u_if.md_use_e = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_e, vecs[i].hi, vecs[i].lo,
                  $sformatf("vec%0d", i));

        // Asynchronous reset in the 3rd busy cycle of a DIV.
        @(negedge clk);
        u_if.start = 1'b1; u_if.md_op = MD_DIV; u_if.rs_val = 32'd100; u_if.rt_val = 32'd3;
        @(negedge clk);
        u_if.start = 1'b0; u_if.md_op = MD_NOP;
        @(negedge clk);
        @(negedge clk);
        #1 check("abort_busy_before", 32'(u_if.busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_hi",   u_if.hi, 32'd0);
        check("abort_lo",   u_if.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        do_op(MD_MULT, 32'd6, 32'hFFFFFFF9, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6, "post_rst");

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = md_op_e'(3'($urandom_range(1, 6)));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            ue = 1'($urandom_range(0, 1));
            h  = m_hi;
            l  = m_lo;
            model(op, a, b, h, l);
            do_op(op, a, b, ue, h, l, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
